// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch prefetch queue.
package ifetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } ifq_state_e;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } ifq_entry_t;

    localparam logic [63:0] INSTR_BYTES = 64'd4;

    function automatic logic [63:0] align_word(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction

    // Saturating 32-bit accumulate used by the optional statistics counters.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/ifq_checker.sv
// Simulation checks for the fetch/memory protocol seen by the prefetch queue.
module ifq_checker #(
    parameter int CNT_W = 3
) (
    input logic             clock,
    input logic             reset,
    input logic             imem_rvalid,
    input logic [CNT_W-1:0] outstanding,
    input logic             imem_req,
    input logic [1:0]       addr_lo
);

    a_rvalid_has_credit: assert property (@(posedge clock) disable iff (reset)
        imem_rvalid |-> (outstanding != '0));

    a_addr_aligned: assert property (@(posedge clock) disable iff (reset)
        imem_req |-> (addr_lo == 2'b00));

endmodule

// File: rtl/ifq_fifo.sv
// Parameterised synchronous FIFO with clear; head is read combinationally from storage.
module ifq_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [95:0]
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic [$clog2(DEPTH):0]   count,
    output T                         head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T                mem_q [DEPTH];
    T                mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_s;
    logic            do_push_s;
    logic            do_pop_s;

    assign full_s    = (count_q == CW'(DEPTH));
    assign do_pop_s  = pop && (count_q != '0) && !clear;
    assign do_push_s = push && (!full_s || do_pop_s) && !clear;
    assign count     = count_q;
    assign head      = mem_q[rd_ptr_q];

    // Next pointer, occupancy and storage values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage and pointer registers; storage is zeroed so the head never shows X.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/ifetch_prefetch_queue.sv
// Instruction-fetch front end: sequential PC generation, credit-limited issue, in-order
// response buffering and redirect flush. Optional statistics enabled by IFQ_STATS_EN.
module ifetch_prefetch_queue
    import ifetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int          CNT_W    = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   redirect_valid,
    input  logic [63:0]            redirect_pc,
    output logic                   imem_req,
    output logic [63:0]            imem_addr,
    input  logic                   imem_rvalid,
    input  logic [31:0]            imem_rdata,
    output logic                   if_valid,
    input  logic                   if_ready,
    output logic [31:0]            if_instr,
    output logic [63:0]            if_pc,
    output logic [$clog2(DEPTH):0] q_count
`ifdef IFQ_STATS_EN
    ,
    output logic [31:0]            stat_fetched,
    output logic [31:0]            stat_squashed,
    output logic [31:0]            stat_stall_cycles
`endif
);

    localparam int QW = $clog2(DEPTH) + 1;
    localparam int SW = CNT_W + 1;

    ifq_state_e        state_q, state_d;
    logic [63:0]       fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  discard_q, discard_d;

    logic [QW-1:0]     fifo_count_s;
    ifq_entry_t        head_s;
    ifq_entry_t        push_entry_s;
    logic [63:0]       rsp_pc_s;
    logic              rsp_ok_s;
    logic              credit_ok_s;
    logic              issue_s;
    logic              push_s;
    logic              pop_s;

    // Responses without a matching request are protocol errors and are ignored.
    assign rsp_ok_s    = imem_rvalid && (outstanding_q != '0);
    assign credit_ok_s = (SW'(fifo_count_s) + SW'(outstanding_q)) < SW'(DEPTH);
    assign issue_s     = (state_q == RUN) && credit_ok_s && !redirect_valid;
    assign push_s      = rsp_ok_s && (state_q == RUN) && !redirect_valid;
    assign pop_s       = if_valid && if_ready;

    // In RUN every in-flight request is sequential, so the oldest one sits this far behind fetch_pc.
    assign rsp_pc_s     = fetch_pc_q - (INSTR_BYTES * 64'(outstanding_q));
    assign push_entry_s = '{pc: rsp_pc_s, instr: imem_rdata};

    assign imem_req  = issue_s;
    assign imem_addr = fetch_pc_q;
    assign if_valid  = !redirect_valid && (fifo_count_s != '0);
    assign if_instr  = head_s.instr;
    assign if_pc     = head_s.pc;
    assign q_count   = fifo_count_s;

    ifq_fifo #(
        .DEPTH (DEPTH),
        .T     (ifq_entry_t)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .clear     (redirect_valid),
        .count     (fifo_count_s),
        .head      (head_s)
    );

    // FSM next state, fetch PC and in-flight bookkeeping.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (redirect_valid) begin
            fetch_pc_d    = align_word(redirect_pc);
            outstanding_d = outstanding_q - (rsp_ok_s ? CNT_W'(1) : CNT_W'(0));
            discard_d     = outstanding_d;
            state_d       = (outstanding_d != '0) ? FLUSH : RUN;
        end else begin
            case (state_q)
                BOOT: begin
                    state_d = RUN;
                end
                RUN: begin
                    if (issue_s) begin
                        fetch_pc_d = fetch_pc_q + INSTR_BYTES;
                    end else begin
                        fetch_pc_d = fetch_pc_q;
                    end
                    case ({issue_s, rsp_ok_s})
                        2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
                        2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
                        default: outstanding_d = outstanding_q;
                    endcase
                end
                FLUSH: begin
                    if (rsp_ok_s) begin
                        outstanding_d = outstanding_q - CNT_W'(1);
                        discard_d     = discard_q - CNT_W'(1);
                        state_d       = (discard_q == CNT_W'(1)) ? RUN : FLUSH;
                    end else begin
                        state_d = FLUSH;
                    end
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end
    end

    // FSM and counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

`ifdef IFQ_STATS_EN
    logic [31:0] stat_fetched_q, stat_fetched_d;
    logic [31:0] stat_squashed_q, stat_squashed_d;
    logic [31:0] stat_stall_q, stat_stall_d;
    logic [31:0] squash_inc_s;

    // Squashed work: entries cleared plus responses dropped by a redirect or during FLUSH.
    always_comb begin
        squash_inc_s = 32'd0;
        if (redirect_valid) begin
            squash_inc_s = 32'(fifo_count_s) + (rsp_ok_s ? 32'd1 : 32'd0);
        end else if (state_q == FLUSH) begin
            squash_inc_s = rsp_ok_s ? 32'd1 : 32'd0;
        end else begin
            squash_inc_s = 32'd0;
        end
        stat_fetched_d  = sat_add32(stat_fetched_q, pop_s ? 32'd1 : 32'd0);
        stat_squashed_d = sat_add32(stat_squashed_q, squash_inc_s);
        stat_stall_d    = sat_add32(stat_stall_q,
                              ((state_q == RUN) && !credit_ok_s && !redirect_valid) ? 32'd1 : 32'd0);
    end

    // Statistics registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_fetched_q  <= 32'd0;
            stat_squashed_q <= 32'd0;
            stat_stall_q    <= 32'd0;
        end else begin
            stat_fetched_q  <= stat_fetched_d;
            stat_squashed_q <= stat_squashed_d;
            stat_stall_q    <= stat_stall_d;
        end
    end

    assign stat_fetched      = stat_fetched_q;
    assign stat_squashed     = stat_squashed_q;
    assign stat_stall_cycles = stat_stall_q;
`endif

    ifq_checker #(
        .CNT_W (CNT_W)
    ) u_checker (
        .clock       (clock),
        .reset       (reset),
        .imem_rvalid (imem_rvalid),
        .outstanding (outstanding_q),
        .imem_req    (imem_req),
        .addr_lo     (imem_addr[1:0])
    );

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Bench for ifetch_prefetch_queue: latency-configurable memory model plus a
// request-level reference model of fetch, buffering and redirect squashing.
module tb_ifetch_prefetch_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic [2:0]  q_count;
`ifdef IFQ_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_squashed;
    logic [31:0] stat_stall_cycles;
`endif

    always #5 clock = ~clock;

    ifetch_prefetch_queue #(
        .DEPTH    (4),
        .RESET_PC (64'd0),
        .CNT_W    (3)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_rvalid       (imem_rvalid),
        .imem_rdata        (imem_rdata),
        .if_valid          (if_valid),
        .if_ready          (if_ready),
        .if_instr          (if_instr),
        .if_pc             (if_pc),
        .q_count           (q_count)
`ifdef IFQ_STATS_EN
        ,
        .stat_fetched      (stat_fetched),
        .stat_squashed     (stat_squashed),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          lat   = 1;
    logic [31:0] salt;

    // memory model: addresses accepted and the cycle each response is due
    logic [63:0] mem_addr_q[$];
    int          mem_due_q[$];

    // reference model
    ent_t        m_fifo[$];
    logic [63:0] m_infl[$];
    bit          m_stale[$];
    logic [63:0] m_pc;
    bit          m_boot;

    bit          seen_req;
    logic [63:0] seen_addr;

    function automatic logic [31:0] word_at(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ salt ^ 32'h9E37_79B9;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive memory response, compare against the model, advance the model.
    task automatic step();
        bit          rv;
        bit          hs;
        bit          exp_req;
        bit          exp_valid;
        logic [63:0] ra;
        logic [63:0] p;
        bit          s;
        ent_t        e;
        rv = 1'b0;
        ra = 64'd0;
        if (mem_due_q.size() > 0 && mem_due_q[0] == cyc) begin
            rv = 1'b1;
            ra = mem_addr_q.pop_front();
            void'(mem_due_q.pop_front());
        end
        imem_rvalid = rv;
        imem_rdata  = rv ? word_at(ra) : $urandom;
        #1;
        hs = 1'b0;
        foreach (m_stale[i]) if (m_stale[i]) hs = 1'b1;
        exp_req   = !redirect_valid && !m_boot && !hs && (m_fifo.size() + m_infl.size() < 4);
        exp_valid = !redirect_valid && (m_fifo.size() > 0);
        chk("imem_req", {63'd0, imem_req}, {63'd0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        chk("if_valid", {63'd0, if_valid}, {63'd0, exp_valid});
        chk("q_count", {61'd0, q_count}, 64'(m_fifo.size()));
        if (exp_valid) begin
            chk("if_pc", if_pc, m_fifo[0].pc);
            chk("if_instr", {32'd0, if_instr}, {32'd0, m_fifo[0].instr});
        end
        seen_req  = imem_req;
        seen_addr = imem_addr;
        if (imem_req) begin
            mem_addr_q.push_back(imem_addr);
            mem_due_q.push_back(cyc + lat);
        end
        if (redirect_valid) begin
            m_fifo.delete();
            if (rv && m_infl.size() > 0) begin
                void'(m_infl.pop_front());
                void'(m_stale.pop_front());
            end
            foreach (m_stale[i]) m_stale[i] = 1'b1;
            m_pc = redirect_pc & ~64'd3;
        end else begin
            if (exp_valid && if_ready) void'(m_fifo.pop_front());
            if (rv && m_infl.size() > 0) begin
                p = m_infl.pop_front();
                s = m_stale.pop_front();
                if (!s) begin
                    e.pc    = p;
                    e.instr = word_at(p);
                    m_fifo.push_back(e);
                end
            end
            if (exp_req) begin
                m_infl.push_back(m_pc);
                m_stale.push_back(1'b0);
                m_pc = m_pc + 64'd4;
            end
        end
        m_boot = 1'b0;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear without waiting for an edge.
    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        imem_rvalid    = 1'b0;
        #1;
        chk("rst_imem_req", {63'd0, imem_req}, 64'd0);
        chk("rst_if_valid", {63'd0, if_valid}, 64'd0);
        chk("rst_if_instr", {32'd0, if_instr}, 64'd0);
        chk("rst_if_pc", if_pc, 64'd0);
        chk("rst_q_count", {61'd0, q_count}, 64'd0);
`ifdef IFQ_STATS_EN
        chk("rst_stat_fetched", {32'd0, stat_fetched}, 64'd0);
        chk("rst_stat_squashed", {32'd0, stat_squashed}, 64'd0);
        chk("rst_stat_stall", {32'd0, stat_stall_cycles}, 64'd0);
`endif
        mem_addr_q.delete();
        mem_due_q.delete();
        m_fifo.delete();
        m_infl.delete();
        m_stale.delete();
        m_pc   = 64'd0;
        m_boot = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic first_req(input string tag, input logic [63:0] exp);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!seen_req && n < 20);
        chk(tag, seen_req ? seen_addr : 64'hDEAD_DEAD_DEAD_DEAD, exp);
    endtask

    initial begin
        logic [63:0] wrap_a[2];
        int          k;
        int          n;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'd0;
        if_ready       = 1'b0;
        salt           = $urandom;
        lat            = 1;
        do_reset();

        // decode stalled: queue fills to 4, then credits run out
        repeat (20) step();
        chk("stall_q_full", {61'd0, q_count}, 64'd4);
        chk("stall_no_req", {63'd0, imem_req}, 64'd0);
        if_ready = 1'b1;
        first_req("resume_pc", 64'd16);

        // steady 1-cycle memory
        repeat (30) step();

        // redirect coinciding with a response and a pop
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_0000_2000;
        step();
        redirect_valid = 1'b0;
        chk("redir_q_empty", {61'd0, q_count}, 64'd0);
        repeat (10) step();

        // fetch PC wraps past the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        k = 0;
        n = 0;
        wrap_a[0] = 64'h1;
        wrap_a[1] = 64'h1;
        while (k < 2 && n < 20) begin
            step();
            n++;
            if (seen_req) begin
                wrap_a[k] = seen_addr;
                k++;
            end
        end
        chk("wrap_first", wrap_a[0], 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_second", wrap_a[1], 64'd0);
        repeat (10) step();

        // 3-cycle memory, redirect with responses in flight
        lat = 3;
        repeat (15) step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_0000_1003;
        step();
        redirect_valid = 1'b0;
        first_req("flush_target", 64'h0000_0000_0000_1000);
        n = 0;
        while (!if_valid && n < 20) begin
            step();
            n++;
        end
        chk("flush_first_pc", if_pc, 64'h0000_0000_0000_1000);

        // randomized decode back-pressure and redirects
        for (int i = 0; i < 400; i++) begin
            if_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = {$urandom, $urandom};
            step();
        end
        redirect_valid = 1'b0;
        if_ready       = 1'b1;

        // reset in the middle of a flush
        repeat (10) step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_0000_8000;
        step();
        redirect_valid = 1'b0;
        step();
        do_reset();
        first_req("post_reset_pc", 64'd0);
        repeat (20) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
